// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Lets two requesters share one external combinational ALU. Only one
//   operation is in flight at a time. Each operation passes through
//   IDLE -> EXEC -> RESP.
//   - Accept: in IDLE, on valid & ready.
//   - EXEC: the ALU is driven from the latched operands for one cycle.
//   - RESP: the captured result is held until the owner takes it.
//   Ties go to the requester that was not granted last.
// Ports
//   clk, reset              : clock, async active-high reset
//   reqN_valid/ready/op/a/b : request channel of requester N (N = 0,1)
//   respN_valid/ready       : response handshake of requester N
//   respN_result/zero       : captured ALU result / zero flag for N
//   alu_ctrl/alu_a/alu_b    : drive the shared ALU (from latched registers)
//   alu_result/alu_zero     : outputs of the shared ALU
//   busy                    : high whenever the FSM is not in IDLE
module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic [WIDTH-1:0] resp0_result,
    output logic             resp0_zero,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp1_result,
    output logic             resp1_zero,
    output logic [2:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             busy
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t             r_state;
    logic               r_owner;       // 0: requester 0, 1: requester 1
    logic               r_last_grant;  // owner of the most recent accept
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res0;
    logic [WIDTH-1:0]   r_res1;
    logic               r_zero0;
    logic               r_zero1;

    logic w_gnt0;
    logic w_gnt1;
    logic w_rsp_ready;

    // Round-robin on a tie: the side that was not granted last wins.
    // These are the grant candidates. They only turn into a handshake in IDLE.
    assign w_gnt0 = req0_valid & (~req1_valid | r_last_grant);
    assign w_gnt1 = req1_valid & (~req0_valid | ~r_last_grant);

    assign req0_ready = (r_state == S_IDLE) & w_gnt0;
    assign req1_ready = (r_state == S_IDLE) & w_gnt1;

    // Only the owner's resp_ready can close a transaction.
    assign w_rsp_ready = r_owner ? resp1_ready : resp0_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_res0       <= '0;
            r_res1       <= '0;
            r_zero0      <= 1'b0;
            r_zero1      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt0 | w_gnt1) begin
                        r_owner      <= w_gnt1;
                        r_last_grant <= w_gnt1;
                        r_op         <= w_gnt1 ? req1_op : req0_op;
                        r_a          <= w_gnt1 ? req1_a  : req0_a;
                        r_b          <= w_gnt1 ? req1_b  : req0_b;
                        r_state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (r_owner) begin
                        r_res1  <= alu_result;
                        r_zero1 <= alu_zero;
                    end else begin
                        r_res0  <= alu_result;
                        r_zero0 <= alu_zero;
                    end
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    if (w_rsp_ready)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The ALU only ever sees latched operands. It never sees the live request buses.
    assign alu_ctrl = r_op;
    assign alu_a    = r_a;
    assign alu_b    = r_b;

    assign resp0_valid  = (r_state == S_RESP) & ~r_owner;
    assign resp1_valid  = (r_state == S_RESP) &  r_owner;
    assign resp0_result = r_res0;
    assign resp0_zero   = r_zero0;
    assign resp1_result = r_res1;
    assign resp1_zero   = r_zero1;
    assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid, req1_valid, req0_ready, req1_ready;
    logic [2:0]   req0_op, req1_op;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         resp0_valid, resp1_valid, resp0_ready, resp1_ready;
    logic [W-1:0] resp0_result, resp1_result;
    logic         resp0_zero, resp1_zero;
    logic [2:0]   alu_ctrl;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic         alu_zero;
    logic         busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp0_result(resp0_result), .resp0_zero(resp0_zero),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp1_result(resp1_result), .resp1_zero(resp1_zero),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
    );

    function automatic logic [W-1:0] alu_fn(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a << b[4:0];
            3'd5: return a >> b[4:0];
            3'd6: return ($signed(a) < $signed(b)) ? 1 : 0;
            default: return a ^ b;
        endcase
    endfunction

    // Shared ALU model
    assign alu_result = alu_fn(alu_ctrl, alu_a, alu_b);
    assign alu_zero   = (alu_result == '0);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0;
        req0_op = 0; req1_op = 0; req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        resp0_ready = 1; resp1_ready = 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        idle_inputs();
        @(negedge clk);
        reset = 0;
    endtask

    // This task starts at a negedge and issues one op for requester `who`.
    // It checks the ready, the latency and the owner-only resp_valid.
    // It returns at a negedge with the DUT back in IDLE.
    task automatic run_txn(input int who, input logic [2:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, output logic [W-1:0] res, output logic z);
        if (who == 0) begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
        else          begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
        resp0_ready = 1; resp1_ready = 1;
        #1;
        check("txn_ready_own", who ? req1_ready : req0_ready, 1);
        check("txn_ready_other", who ? req0_ready : req1_ready, 0);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        check("exec_busy", busy, 1);
        check("exec_no_resp", {resp0_valid, resp1_valid}, 0);
        check("exec_alu_ctrl", alu_ctrl, op);
        check("exec_alu_a", alu_a, a);
        @(negedge clk);
        check("resp_valid_own", who ? resp1_valid : resp0_valid, 1);
        check("resp_valid_other", who ? resp0_valid : resp1_valid, 0);
        res = who ? resp1_result : resp0_result;
        z   = who ? resp1_zero : resp0_zero;
        @(negedge clk);
        check("back_idle", busy, 0);
    endtask

    typedef struct {
        int           who;
        logic [2:0]   op;
        logic [W-1:0] a, b, res;
        logic         z;
    } vec_t;

    vec_t vecs[10];

    // random-phase model state: 0 idle, 1 computing, 2 answer pending
    int           m_phase, m_owner, m_last;
    logic [W-1:0] m_res;
    logic         m_zero;

    initial begin
        logic [W-1:0] r;
        logic         z;
        int           grants[$];
        logic [W-1:0] held_r;
        logic         held_z;

        vecs[0] = '{0, 3'd0, 5, 7, 12, 0};
        vecs[1] = '{1, 3'd1, 9, 9, 0, 1};
        vecs[2] = '{1, 3'd6, 3, 4, 1, 0};
        vecs[3] = '{0, 3'd6, 32'hFFFF_FFFF, 1, 1, 0};
        vecs[4] = '{0, 3'd4, 1, 4, 16, 0};
        vecs[5] = '{1, 3'd5, 32'h8000_0000, 31, 1, 0};
        vecs[6] = '{0, 3'd2, 32'hF0F0, 32'h0FF0, 32'h00F0, 0};
        vecs[7] = '{1, 3'd3, 0, 0, 0, 1};
        vecs[8] = '{0, 3'd7, 5, 5, 0, 1};
        vecs[9] = '{1, 3'd1, 3, 5, 32'hFFFF_FFFE, 0};

        reset = 1;
        idle_inputs();
        #3;
        check("rst_busy", busy, 0);
        check("rst_resp_valid", {resp0_valid, resp1_valid}, 0);
        check("rst_alu", {alu_ctrl, alu_a, alu_b}, 0);
        check("rst_results", {resp0_result, resp1_result}, 0);
        check("rst_zeros", {resp0_zero, resp1_zero}, 0);
        @(negedge clk);
        reset = 0;

        // Table-driven vectors
        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i].who, vecs[i].op, vecs[i].a, vecs[i].b, r, z);
            check($sformatf("vec%0d_result", i), r, vecs[i].res);
            check($sformatf("vec%0d_zero", i), z, vecs[i].z);
        end

        // Tie after reset: req0 first, then alternate while both stay valid
        do_reset();
        req0_valid = 1; req1_valid = 1;
        req0_op = 0; req0_a = 1; req0_b = 1; req1_op = 0; req1_a = 2; req1_b = 2;
        for (int c = 0; c < 60 && grants.size() < 6; c++) begin
            #1;
            if (req0_ready && req1_ready) check("both_ready", 1, 0);
            if (req0_ready) grants.push_back(0);
            if (req1_ready) grants.push_back(1);
            @(negedge clk);
        end
        check("tie_grant_count", grants.size(), 6);
        for (int i = 0; i < grants.size(); i++)
            check($sformatf("tie_grant%0d", i), grants[i], i % 2);
        idle_inputs();
        repeat (3) @(negedge clk);

        // Stall in RESP: result held, no readies, non-owner ready ignored
        req0_valid = 1; req0_op = 3'd0; req0_a = 100; req0_b = 23;
        resp0_ready = 0; resp1_ready = 1;
        @(posedge clk);
        @(negedge clk);
        req0_valid = 0;
        req1_valid = 1; req1_op = 3'd7; req1_a = 1; req1_b = 2;
        @(negedge clk);
        held_r = resp0_result; held_z = resp0_zero;
        check("stall_result", held_r, 123);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stall_valid", resp0_valid, 1);
            check("stall_hold", {resp0_result, resp0_zero}, {held_r, held_z});
            check("stall_readies", {req0_ready, req1_ready}, 0);
            check("stall_busy", busy, 1);
            check("stall_no_resp1", resp1_valid, 0);
        end
        req1_valid = 0;
        resp0_ready = 1;
        @(negedge clk);
        check("stall_release_idle", busy, 0);

        // Async reset in the middle of EXEC aborts the op
        req1_valid = 1; req1_op = 3'd0; req1_a = 7; req1_b = 8;
        @(posedge clk);
        @(negedge clk);
        req1_valid = 0;
        check("abort_in_exec", busy, 1);
        #2 reset = 1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_resp_valid", {resp0_valid, resp1_valid}, 0);
        check("abort_alu", {alu_ctrl, alu_a, alu_b}, 0);
        check("abort_results", {resp1_result, resp1_zero}, 0);
        @(negedge clk);
        reset = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("abort_no_resp", {resp0_valid, resp1_valid, busy}, 0);
        end

        // Random traffic against a transaction-level model
        do_reset();
        m_phase = 0; m_owner = 0; m_last = 1; m_res = 0; m_zero = 0;
        for (int n = 0; n < 600; n++) begin
            int g;
            @(negedge clk);
            check("rnd_resp0_valid", resp0_valid, (m_phase == 2 && m_owner == 0));
            check("rnd_resp1_valid", resp1_valid, (m_phase == 2 && m_owner == 1));
            check("rnd_busy", busy, (m_phase != 0));
            if (m_phase == 2)
                check("rnd_result", m_owner ? {resp1_result, resp1_zero} : {resp0_result, resp0_zero},
                      {m_res, m_zero});
            req0_valid = 1'($urandom_range(0, 1)); req1_valid = 1'($urandom_range(0, 1));
            req0_op = 3'($urandom); req1_op = 3'($urandom);
            req0_a = $urandom; req1_a = $urandom_range(0, 3);
            req0_b = ($urandom_range(0, 3) == 0) ? req0_a : $urandom;
            req1_b = $urandom_range(0, 3);
            resp0_ready = 1'($urandom_range(0, 1)); resp1_ready = 1'($urandom_range(0, 1));
            g = -1;
            if (m_phase == 0) begin
                if (req0_valid && req1_valid) g = 1 - m_last;
                else if (req0_valid) g = 0;
                else if (req1_valid) g = 1;
            end
            #1;
            check("rnd_req0_ready", req0_ready, g == 0);
            check("rnd_req1_ready", req1_ready, g == 1);
            @(posedge clk);
            if (m_phase == 0) begin
                if (g >= 0) begin
                    m_owner = g; m_last = g;
                    m_res = g ? alu_fn(req1_op, req1_a, req1_b) : alu_fn(req0_op, req0_a, req0_b);
                    m_zero = (m_res == 0);
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                m_phase = 2;
            end else if ((m_owner == 0 && resp0_ready) || (m_owner == 1 && resp1_ready)) begin
                m_phase = 0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
